// File: rtl/control_unit.sv
// Instruction sequencer for the ALU/accumulator datapath: fetches from a synchronous
// program memory, decodes, and issues op/operand/accumulator-enable; handles JMP and HALT.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [7:0] ext_data,
  output logic [3:0] operation_code,
  output logic [7:0] data_b,
  output logic       aku_enable,
  output logic       halted
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_EXT  = 2'b01;
  localparam logic [1:0] CLS_JMP  = 2'b10;
  localparam logic [1:0] CLS_HALT = 2'b11;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;

  // Instruction bits [5:4] carry no meaning; kept in ir only for visibility.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[5:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= 8'h00;
      ir             <= 8'h00;
      operation_code <= 4'h0;
      data_b         <= 8'h00;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            pc    <= pc + 8'd1;
            state <= DECODE;
          end
        end
        DECODE: begin
          ir <= prog_data;
          case (prog_data[7:6])
            CLS_IMM, CLS_JMP: begin
              pc    <= pc + 8'd1;
              state <= OPERAND;
            end
            CLS_EXT: begin
              operation_code <= prog_data[3:0];
              data_b         <= ext_data;
              state          <= EXEC;
            end
            CLS_HALT: state <= HALT;
            default:  state <= HALT;
          endcase
        end
        OPERAND: begin
          // ir[7] alone separates JMP from ALU-immediate here.
          if (ir[7:6] == CLS_JMP) begin
            pc    <= prog_data;
            state <= FETCH;
          end else begin
            operation_code <= ir[3:0];
            data_b         <= prog_data;
            state          <= EXEC;
          end
        end
        EXEC:    state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Enables come straight off the state register so reset clears them at once.
  assign prog_addr  = pc;
  assign aku_enable = (state == EXEC);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: behavioural synchronous program memory plus
// hand-computed per-cycle expectations for each instruction class.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic [7:0] prog_addr;
  logic [7:0] prog_data = 8'h00;
  logic [7:0] ext_data = 8'h00;
  logic [3:0] operation_code;
  logic [7:0] data_b;
  logic       aku_enable;
  logic       halted;

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data), .ext_data(ext_data),
    .operation_code(operation_code), .data_b(data_b),
    .aku_enable(aku_enable), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= mem[prog_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
  endtask

  // Leaves the bench #1 after a rising edge in cycle 1 (first FETCH).
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // ALU-immediate, with reset-state checks
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'h5A;
    run = 1'b1;
    @(negedge clk);
    chk("rst_addr", prog_addr, 8'h00);
    chk("rst_op", operation_code, 4'h0);
    chk("rst_db", data_b, 8'h00);
    chk("rst_aku", aku_enable, 1'b0);
    chk("rst_halt", halted, 1'b0);
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("imm_aku_c%0d", k), aku_enable, (k == 4));
      if (k == 1) chk("imm_addr_c1", prog_addr, 8'h00);
      if (k == 4) begin
        chk("imm_op", operation_code, 4'h3);
        chk("imm_db", data_b, 8'h5A);
      end
      if (k == 5) chk("imm_next_addr", prog_addr, 8'h02);
    end

    // ALU-external; ext_data changed after DECODE must not leak into data_b
    clear_mem();
    mem[0] = 8'h47;
    ext_data = 8'h11;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 2) begin
        @(posedge clk);
        #1 ext_data = 8'h99;
        k++;
        @(negedge clk);
      end
      chk($sformatf("ext_aku_c%0d", k), aku_enable, (k == 3));
      if (k >= 3) begin
        chk($sformatf("ext_op_c%0d", k), operation_code, 4'h7);
        chk($sformatf("ext_db_c%0d", k), data_b, 8'h11);
      end
      if (k == 4) chk("ext_next_addr", prog_addr, 8'h01);
    end

    // JMP to 0xFF, instruction there takes its operand from 0x00 after wrap
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'h02;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("jmp_aku_c%0d", k), aku_enable, (k == 7));
      if (k == 1) chk("jmp_addr_c1", prog_addr, 8'h00);
      if (k == 2) chk("jmp_addr_c2", prog_addr, 8'h01);
      if (k == 4) chk("jmp_addr_c4", prog_addr, 8'hFF);
      if (k == 5) chk("jmp_addr_c5", prog_addr, 8'h00);
      if (k == 7) begin
        chk("jmp_op", operation_code, 4'h2);
        chk("jmp_db", data_b, 8'h80);
      end
    end

    // HALT
    clear_mem();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("halt_h_c%0d", k), halted, (k >= 3));
      chk($sformatf("halt_aku_c%0d", k), aku_enable, 1'b0);
      if (k >= 3) chk($sformatf("halt_addr_c%0d", k), prog_addr, 8'h01);
    end

    // Stall with run low, then release
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'h5A;
    run = 1'b0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("stall_addr_c%0d", k), prog_addr, 8'h00);
      chk($sformatf("stall_aku_c%0d", k), aku_enable, 1'b0);
    end
    @(posedge clk);
    #1 run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("go_aku_c%0d", k), aku_enable, (k == 4));
      if (k == 4) chk("go_db", data_b, 8'h5A);
      if (k == 5) chk("go_addr", prog_addr, 8'h02);
    end

    // Asynchronous reset in the middle of EXEC
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'h5A;
    do_reset();
    repeat (4) cyc();
    chk("ar_aku_pre", aku_enable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ar_aku", aku_enable, 1'b0);
    chk("ar_addr", prog_addr, 8'h00);
    chk("ar_halt", halted, 1'b0);
    chk("ar_op", operation_code, 4'h0);
    chk("ar_db", data_b, 8'h00);
    do_reset();
    cyc();
    chk("ar_first_fetch", prog_addr, 8'h00);
    cyc();
    chk("ar_decode_addr", prog_addr, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
